// File: rtl/aes_inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: captures one 128-bit state, runs a shared inverse
// column unit COL_PER_CYCLE columns per cycle, then holds the result until it is taken.
module aes_inv_mix_columns_seq #(
  parameter int COL_PER_CYCLE = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic [1:0]   o_dbg_state
);

  // Handshake: a transfer happens on a rising CLK edge where valid & ready are both 1;
  // a producer holds valid and its data stable until that edge, ready never depends on valid.

  if (!(COL_PER_CYCLE == 1 || COL_PER_CYCLE == 2 || COL_PER_CYCLE == 4)) begin : g_bad_param
    $error("aes_inv_mix_columns_seq: COL_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_col_cnt;
  logic [31:0] r_work [4];
  logic [31:0] r_res  [4];

  logic [1:0]  w_idx [COL_PER_CYCLE];
  logic [31:0] w_col [COL_PER_CYCLE];
  logic        w_last;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 09/0b/0d/0e are assembled from the x2/x4/x8 xtime chain of each byte.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    for (int k = 0; k < COL_PER_CYCLE; k++) begin
      w_idx[k] = r_col_cnt + 2'(k);
      w_col[k] = inv_col(r_work[w_idx[k]]);
    end
  end

  assign w_last = (w_idx[COL_PER_CYCLE-1] == 2'd3);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_col_cnt <= 2'd0;
      for (int c = 0; c < 4; c++) begin
        r_work[c] <= 32'd0;
        r_res[c]  <= 32'd0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            for (int c = 0; c < 4; c++) r_work[c] <= s_data[127-32*c -: 32];
            r_col_cnt <= 2'd0;
            r_state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          for (int k = 0; k < COL_PER_CYCLE; k++) r_res[w_idx[k]] <= w_col[k];
          r_col_cnt <= r_col_cnt + 2'(COL_PER_CYCLE);
          if (w_last) r_state <= ST_OUT;
        end
        ST_OUT: begin
          if (m_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready     = (r_state == ST_IDLE);
  assign m_valid     = (r_state == ST_OUT);
  assign m_data      = {r_res[0], r_res[1], r_res[2], r_res[3]};
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
// Bench for aes_inv_mix_columns_seq: three instances (1, 2 and 4 columns per cycle) checked
// against a GF(2^8) matrix model of MixColumns / InvMixColumns.
module tb_aes_inv_mix_columns_seq;

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

  logic         CLK;
  logic         RESET;
  logic         s_valid [3];
  logic         s_ready [3];
  logic [127:0] s_data  [3];
  logic         m_valid [3];
  logic         m_ready [3];
  logic [127:0] m_data  [3];
  logic [1:0]   dbg     [3];

  int checks;
  int errors;
  int last_lat;
  bit last_rdy_bad;
  logic [127:0] exp_q[$];
  logic [127:0] b2b_in [3];
  logic [1:0]   idle_code [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_mix_columns_seq #(.COL_PER_CYCLE(1 << g)) u_dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .s_valid    (s_valid[g]),
      .s_ready    (s_ready[g]),
      .s_data     (s_data[g]),
      .m_valid    (m_valid[g]),
      .m_ready    (m_ready[g]),
      .m_data     (m_data[g]),
      .o_dbg_state(dbg[g])
    );
  end

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] st, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   a [16];
    logic [7:0]   b;
    logic [127:0] r;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int n = 0; n < 16; n++) a[n] = st[127-8*n -: 8];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b ^= gmul(a[4*c+j], coef[(j - rr + 4) % 4]);
        r[127-8*(4*c+rr) -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks: present a state, wait for accept, then run until m_valid (or budget)
  task automatic run_op(input int u, input logic [127:0] din, output logic [127:0] dout);
    int cyc;
    s_data[u]  = din;
    s_valid[u] = 1'b1;
    cyc = 0;
    while (!s_ready[u] && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
    end
    @(posedge CLK); #1;
    s_valid[u] = 1'b0;
    s_data[u]  = rand128();
    last_lat = 0;
    last_rdy_bad = 1'b0;
    while (!m_valid[u] && last_lat < 50) begin
      if (s_ready[u]) last_rdy_bad = 1'b1;
      @(posedge CLK); #1;
      last_lat++;
    end
    if (s_ready[u]) last_rdy_bad = 1'b1;
    dout = m_data[u];
  endtask

  task automatic drive_b2b(input int u);
    int cyc;
    for (int i = 0; i < 3; i++) begin
      s_data[u]  = b2b_in[i];
      s_valid[u] = 1'b1;
      cyc = 0;
      while (!s_ready[u] && cyc < 200) begin
        @(posedge CLK); #1;
        cyc++;
      end
      @(posedge CLK); #1;
      exp_q.push_back(mix_ref(b2b_in[i], 1'b1));
    end
    s_valid[u] = 1'b0;
  endtask

  task automatic monitor_b2b(input int u);
    int got;
    int cyc;
    logic [127:0] exp_v;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 600) begin
      @(posedge CLK); #1;
      m_ready[u] = 1'($urandom_range(0, 1));
      #1;
      if (m_valid[u] && m_ready[u]) begin
        exp_v = '1;
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        chk("b2b_data", m_data[u], exp_v);
        got++;
      end
      cyc++;
    end
    chk("b2b_count", 128'(got), 128'd3);
    chk("b2b_queue_empty", 128'(exp_q.size()), 128'd0);
    m_ready[u] = 1'b0;
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] orig;
    logic [127:0] exp_v;
    checks = 0;
    errors = 0;
    for (int u = 0; u < 3; u++) begin
      s_valid[u] = 1'b0;
      s_data[u]  = '0;
      m_ready[u] = 1'b0;
    end
    RESET = 1'b1;
    s_valid[0] = 1'b1;
    s_data[0]  = FIPS_IN;

    // reset state, with s_valid asserted but ignored
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    for (int u = 0; u < 3; u++) begin
      chk("rst_m_valid", 128'(m_valid[u]), 128'd0);
      chk("rst_m_data", m_data[u], 128'd0);
      chk("rst_s_ready", 128'(s_ready[u]), 128'd1);
      idle_code[u] = dbg[u];
    end
    s_valid[0] = 1'b0;
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_idle", 128'(s_ready[0]), 128'd1);

    // FIPS vector and latency on every column rate
    for (int u = 0; u < 3; u++) begin
      m_ready[u] = 1'b1;
      run_op(u, FIPS_IN, d);
      chk("fips_data", d, FIPS_OUT);
      chk("fips_model", d, mix_ref(FIPS_IN, 1'b1));
      chk("latency", 128'(last_lat), 128'(4 >> u));
      chk("s_ready_low_busy", 128'(last_rdy_bad), 128'd0);
      @(posedge CLK); #1;
      chk("pulse_m_valid", 128'(m_valid[u]), 128'd0);
      chk("back_idle_s_ready", 128'(s_ready[u]), 128'd1);
      chk("back_idle_state", 128'(dbg[u]), 128'(idle_code[u]));
      m_ready[u] = 1'b0;
    end

    // backpressure: 10 stalled cycles in OUT, then a single transfer
    orig = rand128();
    exp_v = mix_ref(orig, 1'b1);
    run_op(0, orig, d);
    chk("bp_first", d, exp_v);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("bp_m_valid", 128'(m_valid[0]), 128'd1);
      chk("bp_m_data", m_data[0], exp_v);
      chk("bp_s_ready", 128'(s_ready[0]), 128'd0);
    end
    m_ready[0] = 1'b1;
    @(posedge CLK); #1;
    m_ready[0] = 1'b0;
    chk("bp_release_m_valid", 128'(m_valid[0]), 128'd0);
    chk("bp_release_s_ready", 128'(s_ready[0]), 128'd1);
    @(posedge CLK); #1;
    chk("bp_single_transfer", 128'(m_valid[0]), 128'd0);

    // asynchronous reset in the second CALC cycle
    s_data[0]  = rand128();
    s_valid[0] = 1'b1;
    @(posedge CLK); #1;
    s_valid[0] = 1'b0;
    @(posedge CLK); #1;
    #2 RESET = 1'b1;
    #1;
    chk("abort_m_valid", 128'(m_valid[0]), 128'd0);
    chk("abort_m_data", m_data[0], 128'd0);
    chk("abort_s_ready", 128'(s_ready[0]), 128'd1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    m_ready[0] = 1'b1;
    run_op(0, FIPS_IN, d);
    chk("after_abort_data", d, FIPS_OUT);
    @(posedge CLK); #1;
    m_ready[0] = 1'b0;

    // round trip through forward model, plus fixed points
    m_ready[0] = 1'b1;
    run_op(0, 128'd0, d);
    chk("zero_state", d, 128'd0);
    @(posedge CLK); #1;
    m_ready[0] = 1'b0;
    m_ready[1] = 1'b1;
    run_op(1, {4{32'hc6c6c6c6}}, d);
    chk("c6_columns", d, {4{32'hc6c6c6c6}});
    @(posedge CLK); #1;
    m_ready[1] = 1'b0;
    m_ready[2] = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      orig = rand128();
      run_op(2, mix_ref(orig, 1'b0), d);
      chk("round_trip", d, orig);
      @(posedge CLK); #1;
    end
    m_ready[2] = 1'b0;

    // back-to-back with s_valid held and random m_ready stalls
    for (int i = 0; i < 3; i++) b2b_in[i] = rand128();
    exp_q.delete();
    fork
      drive_b2b(1);
      monitor_b2b(1);
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
